// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage. It issues sequential fetches, buffers
// in-order responses in a small prefetch FIFO, handles redirects, and
// injects NOP bubbles (32'h0) when no instruction is ready.
// Ports:
//   clk, rst (async, active-low)
//   imem_req_valid_o/imem_req_ready_i/imem_addr_o : fetch request channel
//   imem_rsp_valid_i/imem_rsp_data_i               : in-order response channel
//   stall_i, pc_sel_i, target_i                    : hold / redirect from control
//   inst_o, pc_o, pc4_o                            : decode-facing outputs
module fetch_unit #(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int          FIFO_DEPTH      = 2,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid_o,
    input  logic        imem_req_ready_i,
    output logic [31:0] imem_addr_o,
    input  logic        imem_rsp_valid_i,
    input  logic [31:0] imem_rsp_data_i,
    input  logic        stall_i,
    input  logic        pc_sel_i,
    input  logic [31:0] target_i,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc4_o
);

    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int FW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [31:0]   fetch_pc;
    logic [31:0]   rsp_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] outstanding_nxt;
    logic [CW-1:0] drop;
    logic [FW-1:0] fifo_count;
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [31:0]   fifo_inst [FIFO_DEPTH];
    logic [31:0]   fifo_pc   [FIFO_DEPTH];
    logic [31:0]   target_al;
    logic          accept;
    logic          rsp_take;
    logic          push;
    logic          pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (32'(p) == 32'(FIFO_DEPTH - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    assign target_al = {target_i[31:2], 2'b00};

    // Counting outstanding requests against the FIFO guarantees every
    // kept response finds a free slot.
    assign imem_req_valid_o = rst && !pc_sel_i
        && (32'(outstanding) < 32'(MAX_OUTSTANDING))
        && (32'(outstanding) + 32'(fifo_count) < 32'(FIFO_DEPTH));
    assign imem_addr_o = fetch_pc;

    assign accept   = imem_req_valid_o && imem_req_ready_i;
    assign rsp_take = imem_rsp_valid_i && (outstanding != '0);
    assign push     = rsp_take && (drop == '0);
    assign pop      = !pc_sel_i && !stall_i && (fifo_count != '0);

    assign outstanding_nxt = outstanding + CW'(accept) - CW'(rsp_take);
    assign pc4_o = pc_o + 32'd4;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
            fifo_count  <= '0;
            head        <= '0;
            tail        <= '0;
            inst_o      <= '0;
            pc_o        <= RESET_PC;
        end else begin
            outstanding <= outstanding_nxt;
            if (pc_sel_i) begin
                // Everything still in flight belongs to the old path.
                fetch_pc   <= target_al;
                rsp_pc     <= target_al;
                drop       <= outstanding_nxt;
                fifo_count <= '0;
                head       <= '0;
                tail       <= '0;
                inst_o     <= '0;
                pc_o       <= target_al;
            end else begin
                if (accept) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (rsp_take && (drop != '0)) begin
                    drop <= drop - 1'b1;
                end
                if (push) begin
                    tail   <= ptr_inc(tail);
                    rsp_pc <= rsp_pc + 32'd4;
                end
                if (pop) begin
                    head <= ptr_inc(head);
                end
                fifo_count <= fifo_count + FW'(push) - FW'(pop);
                if (!stall_i) begin
                    if (fifo_count != '0) begin
                        inst_o <= fifo_inst[head];
                        pc_o   <= fifo_pc[head];
                    end else begin
                        inst_o <= '0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_inst[tail] <= imem_rsp_data_i;
            fifo_pc[tail]   <= rsp_pc;
        end
    end

    always @(posedge clk) begin
        if (rst && imem_rsp_valid_i) begin
            assert (outstanding != '0);
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and randomized checks of fetch_unit against a
// queue-based memory and instruction-stream reference model.
module tb_fetch_unit;

    localparam logic [31:0] RPC   = 32'h0000_0100;
    localparam int          DEPTH = 2;
    localparam int          MAXO  = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid_o;
    logic        imem_req_ready_i;
    logic [31:0] imem_addr_o;
    logic        imem_rsp_valid_i;
    logic [31:0] imem_rsp_data_i;
    logic        stall_i;
    logic        pc_sel_i;
    logic [31:0] target_i;
    logic [31:0] inst_o;
    logic [31:0] pc_o;
    logic [31:0] pc4_o;

    always #5 clk = ~clk;

    fetch_unit #(
        .RESET_PC(RPC),
        .FIFO_DEPTH(DEPTH),
        .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .imem_req_valid_o(imem_req_valid_o),
        .imem_req_ready_i(imem_req_ready_i),
        .imem_addr_o(imem_addr_o),
        .imem_rsp_valid_i(imem_rsp_valid_i),
        .imem_rsp_data_i(imem_rsp_data_i),
        .stall_i(stall_i),
        .pc_sel_i(pc_sel_i),
        .target_i(target_i),
        .inst_o(inst_o),
        .pc_o(pc_o),
        .pc4_o(pc4_o)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          stale;
    } req_t;

    req_t        memq[$];
    logic [31:0] fifoq[$];
    logic [31:0] acc_log[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          min_lat = 1;
    int          max_lat = 1;
    int          delivered = 0;
    logic [31:0] exp_issue;
    logic [31:0] exp_inst;
    logic [31:0] exp_pc;

    function automatic logic [31:0] word(input logic [31:0] a);
        return ((a ^ 32'h5A5A_0000) * 32'h9E37_79B1) | 32'h1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: drive memory response, check the request side, clock,
    // advance the reference model, check the decode-facing outputs.
    task automatic cycle();
        bit          rsp_now;
        bit          acc;
        bit          pop;
        bit          expv;
        bit          sel;
        bit          stl;
        logic [31:0] addr_s;
        logic [31:0] tgt;
        logic [31:0] popped;
        req_t        e;
        popped  = '0;
        rsp_now = (memq.size() > 0) && (memq[0].due <= cyc);
        imem_rsp_valid_i = rsp_now;
        imem_rsp_data_i  = rsp_now ? word(memq[0].addr) : $urandom;
        #1;
        sel  = pc_sel_i;
        stl  = stall_i;
        tgt  = target_i;
        expv = !sel && (memq.size() < MAXO)
            && (memq.size() + fifoq.size() < DEPTH);
        chk("req_valid", 32'(imem_req_valid_o), 32'(expv));
        if (imem_req_valid_o) chk("req_addr", imem_addr_o, exp_issue);
        acc    = imem_req_valid_o && imem_req_ready_i;
        addr_s = imem_addr_o;
        pop    = !sel && !stl && (fifoq.size() > 0);
        @(posedge clk);
        cyc++;
        if (pop) popped = fifoq.pop_front();
        if (rsp_now) begin
            e = memq.pop_front();
            if (!e.stale) fifoq.push_back(e.addr);
        end
        if (acc) begin
            memq.push_back('{addr_s,
                cyc + int'($urandom_range(max_lat - 1, min_lat - 1)), 1'b0});
            acc_log.push_back(addr_s);
            exp_issue = exp_issue + 32'd4;
        end
        if (sel) begin
            foreach (memq[i]) memq[i].stale = 1'b1;
            fifoq.delete();
            exp_issue = {tgt[31:2], 2'b00};
            exp_pc    = exp_issue;
            exp_inst  = '0;
        end else if (!stl) begin
            if (pop) begin
                exp_pc   = popped;
                exp_inst = word(popped);
                delivered++;
            end else begin
                exp_inst = '0;
            end
        end
        #1;
        chk("inst_o", inst_o, exp_inst);
        chk("pc_o", pc_o, exp_pc);
        chk("pc4_o", pc4_o, exp_pc + 32'd4);
    endtask

    initial begin
        rst = 1'b0;
        imem_req_ready_i = 1'b0;
        imem_rsp_valid_i = 1'b0;
        imem_rsp_data_i  = '0;
        stall_i  = 1'b0;
        pc_sel_i = 1'b0;
        target_i = '0;
        exp_issue = RPC;
        exp_pc    = RPC;
        exp_inst  = '0;

        // reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_inst", inst_o, 32'h0);
        chk("rst_pc", pc_o, RPC);
        chk("rst_pc4", pc4_o, RPC + 32'd4);
        chk("rst_valid", 32'(imem_req_valid_o), 32'h0);
        rst = 1'b1;

        // first fetch, then back-pressure holds the next address
        imem_req_ready_i = 1'b1;
        cycle();
        imem_req_ready_i = 1'b0;
        cycle();
        chk("t2_addr0", imem_addr_o, 32'h104);
        chk("t1_bubble", inst_o, 32'h0);
        cycle();
        chk("t2_addr1", imem_addr_o, 32'h104);
        chk("t1_first", inst_o, word(32'h100));
        cycle();
        chk("t2_addr2", imem_addr_o, 32'h104);
        chk("t2_valid", 32'(imem_req_valid_o), 32'h1);
        imem_req_ready_i = 1'b1;
        cycle();
        chk("t2_next", imem_addr_o, 32'h108);
        repeat (6) cycle();

        // stall with a full FIFO
        stall_i = 1'b1;
        repeat (6) cycle();
        chk("t3_valid", 32'(imem_req_valid_o), 32'h0);
        stall_i = 1'b0;
        repeat (6) cycle();

        // redirect with two requests in flight
        min_lat = 4;
        max_lat = 4;
        for (int i = 0; i < 20 && memq.size() < 2; i++) cycle();
        chk("t4_setup", 32'(memq.size()), 32'd2);
        pc_sel_i = 1'b1;
        target_i = 32'h2002;
        cycle();
        pc_sel_i = 1'b0;
        chk("t4_pc", pc_o, 32'h2000);
        chk("t4_inst", inst_o, 32'h0);
        min_lat = 1;
        max_lat = 1;
        repeat (12) cycle();

        // PC wrap at the top of the address space
        acc_log.delete();
        pc_sel_i = 1'b1;
        target_i = 32'hFFFF_FFFC;
        cycle();
        pc_sel_i = 1'b0;
        chk("t5_pc4", pc4_o, 32'h0);
        for (int i = 0; i < 12 && acc_log.size() < 2; i++) cycle();
        chk("t5_first", (acc_log.size() > 0) ? acc_log[0] : 32'hx,
            32'hFFFF_FFFC);
        chk("t5_wrap", (acc_log.size() > 1) ? acc_log[1] : 32'hx, 32'h0);
        repeat (8) cycle();

        // asynchronous reset with data buffered
        stall_i = 1'b1;
        repeat (4) cycle();
        #2;
        rst = 1'b0;
        #1;
        chk("t6_inst", inst_o, 32'h0);
        chk("t6_pc", pc_o, RPC);
        chk("t6_pc4", pc4_o, RPC + 32'd4);
        chk("t6_valid", 32'(imem_req_valid_o), 32'h0);
        memq.delete();
        fifoq.delete();
        acc_log.delete();
        exp_issue = RPC;
        exp_pc    = RPC;
        exp_inst  = '0;
        stall_i   = 1'b0;
        imem_rsp_valid_i = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        cycle();
        chk("t6_resume", (acc_log.size() > 0) ? acc_log[0] : 32'hx, RPC);
        repeat (4) cycle();

        // randomized traffic
        delivered = 0;
        min_lat = 1;
        max_lat = 3;
        for (int n = 0; n < 800; n++) begin
            imem_req_ready_i = ($urandom_range(3, 0) != 0);
            stall_i  = ($urandom_range(4, 0) == 0);
            pc_sel_i = ($urandom_range(19, 0) == 0);
            target_i = ($urandom_range(3, 0) == 0)
                ? (32'hFFFF_FFF0 | 32'($urandom_range(15, 0)))
                : $urandom;
            cycle();
        end
        pc_sel_i = 1'b0;
        stall_i  = 1'b0;
        chk("progress", 32'(delivered > 80), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
